// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit: decodes RV32I compute words, drives an external ALU and
// writes results back to a 32x32 register file, one instruction at a time.
// Optional macro: ALU_ISSUE_PERF_EN adds retired/illegal event counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_unit #(
  parameter int          RESET_PC_UNUSED = 0,
  parameter logic [31:0] REG_INIT        = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic        instr_ready,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] retired_count,
  output logic [31:0] illegal_count
`endif
);

  if (RESET_PC_UNUSED != 0) begin : g_reset_pc_check
    $error("RESET_PC_UNUSED is reserved and must be 0");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [4:0]         opcode_q, opcode_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        result_q, result_d;
  logic               wb_valid_q, wb_valid_d;
  logic               illegal_q, illegal_d;
  logic [31:0][31:0]  regs_q, regs_d;

  logic [4:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_illegal;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;

  assign f3    = instr_q[14:12];
  assign f7    = instr_q[31:25];
  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};

  always_comb begin
    dec_op      = 5'd0;
    dec_a       = regs_q[instr_q[19:15]];
    dec_b       = regs_q[instr_q[24:20]];
    dec_illegal = 1'b0;
    case (instr_q[6:0])
      7'b0110011: begin
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000)      dec_op = 5'd0;
            else if (f7 == 7'b0100000) dec_op = 5'd1;
            else                       dec_illegal = 1'b1;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      dec_op = 5'd6;
            else if (f7 == 7'b0100000) dec_op = 5'd7;
            else                       dec_illegal = 1'b1;
          end
          default: begin
            dec_illegal = (f7 != 7'b0000000);
            case (f3)
              3'b001:  dec_op = 5'd5;
              3'b010:  dec_op = 5'd8;
              3'b011:  dec_op = 5'd9;
              3'b100:  dec_op = 5'd4;
              3'b110:  dec_op = 5'd3;
              default: dec_op = 5'd2;
            endcase
          end
        endcase
      end
      7'b0010011: begin
        dec_b = imm_i;
        case (f3)
          3'b000: dec_op = 5'd10;
          3'b010: dec_op = 5'd17;
          3'b011: dec_op = 5'd18;
          3'b100: dec_op = 5'd13;
          3'b110: dec_op = 5'd12;
          3'b111: dec_op = 5'd11;
          3'b001: begin
            dec_op      = 5'd14;
            dec_illegal = (f7 != 7'b0000000);
          end
          default: begin
            if (f7 == 7'b0000000)      dec_op = 5'd15;
            else if (f7 == 7'b0100000) dec_op = 5'd16;
            else                       dec_illegal = 1'b1;
          end
        endcase
      end
      7'b0110111: begin
        // The ALU performs the <<12 itself, so only the raw immediate is sent.
        dec_op = 5'd19;
        dec_a  = 32'h0;
        dec_b  = {12'b0, instr_q[31:12]};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    opcode_d   = opcode_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rd_d       = rd_q;
    result_d   = result_q;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;
    regs_d     = regs_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          opcode_d = dec_op;
          op_a_d   = dec_a;
          op_b_d   = dec_b;
          rd_d     = instr_q[11:7];
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d   = alu_result;
        wb_valid_d = 1'b1;
        state_d    = S_WB;
      end
      default: begin
        if (rd_q != 5'd0) regs_d[rd_q] = result_q;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retired_count_q, retired_count_d;
  logic [31:0] illegal_count_q, illegal_count_d;

  always_comb begin
    retired_count_d = retired_count_q + {31'b0, wb_valid_q};
    illegal_count_d = illegal_count_q + {31'b0, illegal_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_count_q <= 32'h0;
      illegal_count_q <= 32'h0;
    end else begin
      retired_count_q <= retired_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign retired_count = retired_count_q;
  assign illegal_count = illegal_count_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= 32'h0;
      opcode_q   <= 5'd0;
      op_a_q     <= 32'h0;
      op_b_q     <= 32'h0;
      rd_q       <= 5'd0;
      result_q   <= 32'h0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      regs_q     <= {{31{REG_INIT}}, 32'h0};
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      opcode_q   <= opcode_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
      regs_q     <= regs_d;
    end
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign alu_opcode    = opcode_q;
  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = rd_q;
  assign wb_data       = result_q;
  assign illegal       = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit: directed vectors for alu_issue_unit with a behavioural
// ALU attached. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_unit;

  localparam logic [31:0] C_REG_INIT = 32'h0000_0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_data = 32'h0;
  logic        instr_ready;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] illegal_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(
    .RESET_PC_UNUSED(0),
    .REG_INIT       (C_REG_INIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_ready  (instr_ready),
    .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .illegal      (illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .retired_count(retired_count),
    .illegal_count(illegal_count)
`endif
  );

  // Behavioural model of the external combinational ALU.
  function automatic logic [31:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'd0, 5'd10: return a + b;
      5'd1:        return a - b;
      5'd2, 5'd11: return a & b;
      5'd3, 5'd12: return a | b;
      5'd4, 5'd13: return a ^ b;
      5'd5, 5'd14: return a << b[4:0];
      5'd6, 5'd15: return a >> b[4:0];
      5'd7, 5'd16: return $unsigned($signed(a) >>> b[4:0]);
      5'd8, 5'd17: return {31'b0, $signed(a) < $signed(b)};
      5'd9, 5'd18: return {31'b0, a < b};
      5'd19:       return b << 12;
      default:     return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_opcode, alu_operand_a, alu_operand_b);

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_b;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    for (int k = 0; k < 20 && instr_ready !== 1'b1; k++) @(negedge clk);
    check({tag, " ready_before"}, {31'b0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_data  = v.instr;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check({tag, " ready_decode"}, {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    if (v.ill) begin
      check({tag, " illegal_pulse"}, {31'b0, illegal}, 32'd1);
      check({tag, " ready_after_ill"}, {31'b0, instr_ready}, 32'd1);
      check({tag, " no_wb_ill"}, {31'b0, wb_valid}, 32'd0);
      @(negedge clk);
      check({tag, " illegal_width"}, {31'b0, illegal}, 32'd0);
      check({tag, " no_wb_ill2"}, {31'b0, wb_valid}, 32'd0);
    end else begin
      check({tag, " alu_opcode"}, {27'b0, alu_opcode}, {27'b0, v.op});
      if (v.chk_b) check({tag, " alu_operand_b"}, alu_operand_b, v.b);
      check({tag, " ready_exec"}, {31'b0, instr_ready}, 32'd0);
      check({tag, " no_illegal"}, {31'b0, illegal}, 32'd0);
      @(negedge clk);
      check({tag, " wb_valid"}, {31'b0, wb_valid}, 32'd1);
      check({tag, " wb_rd"}, {27'b0, wb_rd}, {27'b0, v.rd});
      check({tag, " wb_data"}, wb_data, v.data);
      check({tag, " ready_wb"}, {31'b0, instr_ready}, 32'd0);
      @(negedge clk);
      check({tag, " wb_width"}, {31'b0, wb_valid}, 32'd0);
      check({tag, " ready_idle"}, {31'b0, instr_ready}, 32'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 1'b0, 5'd10, 5'd1,  32'h00000005, 1'b1, 32'h00000005};
    vecs[1]  = '{32'h40100133, 1'b0, 5'd1,  5'd2,  32'hFFFFFFFB, 1'b1, 32'h00000005};
    vecs[2]  = '{32'h40115213, 1'b0, 5'd16, 5'd4,  32'hFFFFFFFD, 1'b1, 32'h00000401};
    vecs[3]  = '{32'h123451B7, 1'b0, 5'd19, 5'd3,  32'h12345000, 1'b1, 32'h00012345};
    vecs[4]  = '{32'h00000000, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0};
    vecs[5]  = '{32'h00700013, 1'b0, 5'd10, 5'd0,  32'h00000007, 1'b0, 32'h0};
    vecs[6]  = '{32'h000002B3, 1'b0, 5'd0,  5'd5,  32'h00000000, 1'b0, 32'h0};
    vecs[7]  = '{32'h00038333, 1'b0, 5'd0,  5'd6,  32'h00000011, 1'b0, 32'h0};
    vecs[8]  = '{32'h00112433, 1'b0, 5'd8,  5'd8,  32'h00000001, 1'b0, 32'h0};
    vecs[9]  = '{32'h001134B3, 1'b0, 5'd9,  5'd9,  32'h00000000, 1'b0, 32'h0};
    vecs[10] = '{32'h00115533, 1'b0, 5'd6,  5'd10, 32'h07FFFFFF, 1'b0, 32'h0};
    vecs[11] = '{32'hFFF0C593, 1'b0, 5'd13, 5'd11, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFF};
    vecs[12] = '{32'h020000B3, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0};
    vecs[13] = '{32'h40001093, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0};
    vecs[14] = '{32'h0020F633, 1'b0, 5'd2,  5'd12, 32'h00000001, 1'b0, 32'h0};
    vecs[15] = '{32'h00409693, 1'b0, 5'd14, 5'd13, 32'h00000050, 1'b0, 32'h0};
    vecs[16] = '{32'h00002083, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0};
    vecs[17] = '{32'h0060B713, 1'b0, 5'd18, 5'd14, 32'h00000001, 1'b0, 32'h0};
    vecs[18] = '{32'h7FF06793, 1'b0, 5'd12, 5'd15, 32'h000007FF, 1'b1, 32'h000007FF};
    vecs[19] = '{32'h40001033, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0};
    vecs[20] = '{32'h00F78833, 1'b0, 5'd0,  5'd16, 32'h00000FFE, 1'b0, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset instr_ready", {31'b0, instr_ready}, 32'd1);
    check("reset wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset illegal", {31'b0, illegal}, 32'd0);
    check("reset alu_opcode", {27'b0, alu_opcode}, 32'd0);
    check("reset alu_operand_a", alu_operand_a, 32'h0);
    check("reset alu_operand_b", alu_operand_b, 32'h0);
    check("reset wb_rd", {27'b0, wb_rd}, 32'd0);
    check("reset wb_data", wb_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++) run(vecs[i], $sformatf("v%0d", i));

`ifdef ALU_ISSUE_PERF_EN
    check("retired_count", retired_count, 32'd16);
    check("illegal_count", illegal_count, 32'd5);
`endif

    // Abort ADDI x1,x0,9 with a reset while it sits in EXEC.
    for (int k = 0; k < 20 && instr_ready !== 1'b1; k++) @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = 32'h00900093;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort in exec", {27'b0, alu_opcode}, 32'd10);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort no wb", {31'b0, wb_valid}, 32'd0);
    check("abort ready in reset", {31'b0, instr_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort ready after release", {31'b0, instr_ready}, 32'd1);
    check("abort still no wb", {31'b0, wb_valid}, 32'd0);
    // ADD x17,x1,x0 must observe the reset value of x1, not 9.
    run('{32'h000088B3, 1'b0, 5'd0, 5'd17, C_REG_INIT, 1'b0, 32'h0}, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
